legv8_execute_unit: RTL
=======================

Name: legv8_execute_unit

Overview:
- Parametrised LEGv8 execute stage (EX) between decode/register-read and memory access.
- Computes the ALU result, the NZCV flags and the unconditional/conditional branch target (pc + (imm << 2)).
- Presents results through a valid/ready registered output slot, so the stage can stall and flush.
- Adds shifts, flag generation and an optional iterative multiplier.

Parameters:
- WIDTH, 64 (`LEGV8_INTEGER_SZ): operand/result width; legal 8..64, power of two.
- TAG_W, 5: width of the destination-register tag carried alongside the result.
- SHAMT_W, $clog2(WIDTH): shift-amount bits taken from opB.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  input operation valid
- in_ready  out  1  stage can accept an operation
- in_opA  in  WIDTH  register operand A
- in_opB  in  WIDTH  register operand B
- in_imm  in  WIDTH  sign-extended immediate
- in_pc  in  WIDTH  PC of the instruction
- in_alusrc  in  1  1: operand B = in_imm
- in_func  in  4  ALU function code
- in_setflags  in  1  update NZCV (ADDS/SUBS/ANDS)
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result slot valid
- out_ready  in  1  downstream accepts the result
- out_result  out  WIDTH  ALU result
- out_zero  out  1  out_result == 0
- out_branch_target  out  WIDTH  in_pc + (in_imm << 2), truncated to WIDTH
- out_tag  out  TAG_W  tag of the result
- out_flags  out  4  architectural NZCV register {N,Z,C,V}

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_result=0, out_zero=1, out_branch_target=0, out_tag=0, out_flags=0, FSM=IDLE.
- Function codes (B = in_alusrc ? in_imm : in_opB):
  - 0000 AND; 0001 ORR; 0010 ADD; 0110 SUB (A-B).
  - 0111 SLT: unsigned A<B gives 1, else 0.
  - 1100 NOR.
  - 0011 LSL by B[SHAMT_W-1:0]; 0100 LSR (logical) by B[SHAMT_W-1:0].
  - 1000 MUL (optional feature).
  - Any other code: result 0, flags untouched.
- Arithmetic:
  - Modulo 2^WIDTH.
  - C = carry-out for ADD; C = NOT borrow for SUB.
  - V = signed overflow.
  - Logic, shift and SLT ops set C=V=0.
  - N = result[WIDTH-1]; Z = result==0.
- in_ready = (FSM==IDLE) && (!out_valid || out_ready) && !flush.
- Accept occurs when in_valid && in_ready.
- Single-cycle ops: result, tag and branch target are registered on the accept edge; out_valid=1 the next cycle (latency 1). Back-to-back throughput is 1 per cycle while out_ready=1.
- out_flags updates on the same edge as out_result, only if in_setflags and the func is valid.
- Output hold: while out_valid && !out_ready, all out_* remain stable.
- FSM:
  - IDLE: accepted MUL goes to BUSY; other ops stay in IDLE.
  - BUSY: radix-2 shift-add, one bit per cycle, cnt counts 0..WIDTH-1. At cnt==WIDTH-1, load the output slot and go to IDLE.
  - MUL latency = WIDTH+1 cycles from accept to out_valid. The output slot is guaranteed empty because entry required it and in_ready=0 while BUSY.
- Flush: clears out_valid, aborts any BUSY multiply (FSM to IDLE, cnt to 0), discards a simultaneous in_valid. out_flags are NOT rolled back. Flush has priority over every other event.
- Reset mid-multiply: FSM goes to IDLE immediately (async); partial product is discarded.
- out_zero is derived from registered out_result.

Optional Feature:
- LEGV8_EX_MUL_EN
  - Defined: BUSY state and multiplier datapath are present; func 1000 returns the low WIDTH bits of A*B. With setflags, N/Z update and C=V=0.
  - Undefined: no BUSY state; func 1000 behaves as an undefined code (result 0, latency 1, flags untouched).

Decomposition:
- Package legv8_ex_pkg holds:
  - alu_func_e enum with the codes above.
  - ex_state_e {IDLE, BUSY}.
  - nzcv_t packed struct.
- Sub-module legv8_alu_core: purely combinational; computes result and NZCV from A, B, func. The execute unit wraps it with the handshake, FSM, multiplier and registers.

Test Plan:
- Reset: hold rst_n=0 mid-stream -> all outputs at reset values, in_ready=1 one cycle after release.
- ADDS, WIDTH=64: A=0xFFFF_FFFF_FFFF_FFFF, B=1, setflags=1 -> next cycle out_result=0, out_zero=1, out_flags=0b0110.
- SUBS: A=0x8000_0000_0000_0000, B=1 -> result 0x7FFF_FFFF_FFFF_FFFF, flags=0b0011.
- Branch target and shift: alusrc=1, imm=-4, pc=0x100 -> out_branch_target=0xF0. LSL with A=1, imm=63 -> result 0x8000_0000_0000_0000.
- Backpressure: 3 back-to-back ADDs with out_ready=0 from cycle 2 -> first result held stable, in_ready=0, no result lost; release gives results in order with tags 1,2,3.
- MUL (LEGV8_EX_MUL_EN): A=7, B=6 -> out_valid after 65 cycles with result 42 and in_ready=0 meanwhile. Repeat with flush at cycle 10 -> no out_valid, in_ready=1 next cycle, flags unchanged.

Source files
------------

// File: rtl/legv8_ex_pkg.sv
// ============================================================================
// legv8_ex_pkg : shared types for the LEGv8 execute stage
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef LEGV8_INTEGER_SZ
`define LEGV8_INTEGER_SZ 64
`endif

package legv8_ex_pkg;

    typedef enum logic [3:0] {
        FN_AND = 4'b0000,
        FN_ORR = 4'b0001,
        FN_ADD = 4'b0010,
        FN_LSL = 4'b0011,
        FN_LSR = 4'b0100,
        FN_SUB = 4'b0110,
        FN_SLT = 4'b0111,
        FN_MUL = 4'b1000,
        FN_NOR = 4'b1100
    } alu_func_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ex_state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

`default_nettype wire

// File: rtl/legv8_alu_core.sv
// ============================================================================
// legv8_alu_core : combinational LEGv8 ALU (result + NZCV), no multiply
// Rev 1.0
// ============================================================================
`default_nettype none

module legv8_alu_core
    import legv8_ex_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       func_i,
    output logic [WIDTH-1:0] result_o,
    output nzcv_t            flags_o,
    output logic             valid_o
);

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_c;
    logic               w_v;

    // Subtraction as A + ~B + 1 so the top bit is directly NOT borrow.
    assign w_sum   = {1'b0, a_i} + {1'b0, b_i};
    assign w_diff  = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
    assign w_shamt = b_i[SHAMT_W-1:0];

    always_comb begin
        result_o = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        valid_o  = 1'b1;
        case (func_i)
            FN_AND: result_o = a_i & b_i;
            FN_ORR: result_o = a_i | b_i;
            FN_NOR: result_o = ~(a_i | b_i);
            FN_ADD: begin
                result_o = w_sum[WIDTH-1:0];
                w_c      = w_sum[WIDTH];
                w_v      = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            FN_SUB: begin
                result_o = w_diff[WIDTH-1:0];
                w_c      = w_diff[WIDTH];
                w_v      = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            FN_SLT: result_o = {{(WIDTH-1){1'b0}}, ~w_diff[WIDTH]};
            FN_LSL: result_o = a_i << w_shamt;
            FN_LSR: result_o = a_i >> w_shamt;
            default: valid_o = 1'b0;
        endcase
    end

    assign flags_o.n = result_o[WIDTH-1];
    assign flags_o.z = (result_o == '0);
    assign flags_o.c = w_c;
    assign flags_o.v = w_v;

endmodule

`default_nettype wire

// File: rtl/legv8_execute_unit.sv
// ============================================================================
// legv8_execute_unit : LEGv8 EX stage with valid/ready output slot, NZCV
// register and optional iterative multiplier (macro LEGV8_EX_MUL_EN).
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef LEGV8_INTEGER_SZ
`define LEGV8_INTEGER_SZ 64
`endif

module legv8_execute_unit
    import legv8_ex_pkg::*;
#(
    parameter int WIDTH   = `LEGV8_INTEGER_SZ,
    parameter int TAG_W   = 5,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_opA,
    input  logic [WIDTH-1:0] in_opB,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [WIDTH-1:0] in_pc,
    input  logic             in_alusrc,
    input  logic [3:0]       in_func,
    input  logic             in_setflags,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_branch_target,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags
);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_bt;
    logic [WIDTH-1:0] w_alu_result;
    nzcv_t            w_alu_flags;
    logic             w_alu_valid;

    logic             w_accept;
    logic             w_busy;
    logic             w_is_mul;
    logic             w_mul_done;
    logic             w_load_alu;
    logic             w_load_mul;
    logic [WIDTH-1:0] w_mul_result;
    logic [WIDTH-1:0] w_mul_bt;
    logic [TAG_W-1:0] w_mul_tag;
    logic             w_mul_setflags;
    nzcv_t            w_mul_flags;

    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [WIDTH-1:0] out_bt_q,     out_bt_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;
    nzcv_t            flags_q,      flags_d;

    assign w_b  = in_alusrc ? in_imm : in_opB;
    assign w_bt = in_pc + (in_imm << 2);

    legv8_alu_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_alu (
        .a_i      (in_opA),
        .b_i      (w_b),
        .func_i   (in_func),
        .result_o (w_alu_result),
        .flags_o  (w_alu_flags),
        .valid_o  (w_alu_valid)
    );

    assign in_ready   = !w_busy && (!out_valid_q || out_ready) && !flush;
    assign w_accept   = in_valid && in_ready;
    assign w_load_alu = w_accept && !w_is_mul;
    assign w_load_mul = w_mul_done && !flush;

    assign w_mul_flags.n = w_mul_result[WIDTH-1];
    assign w_mul_flags.z = (w_mul_result == '0);
    assign w_mul_flags.c = 1'b0;
    assign w_mul_flags.v = 1'b0;

`ifdef LEGV8_EX_MUL_EN
    localparam logic [0:0]         S_IDLE   = IDLE;
    localparam logic [0:0]         S_BUSY   = BUSY;
    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    logic [0:0]         state_q,    state_d;
    logic [SHAMT_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0]   mcand_q,    mcand_d;
    logic [WIDTH-1:0]   mplier_q,   mplier_d;
    logic [WIDTH-1:0]   prod_q,     prod_d;
    logic [WIDTH-1:0]   mbt_q,      mbt_d;
    logic [TAG_W-1:0]   mtag_q,     mtag_d;
    logic               msf_q,      msf_d;
    logic [WIDTH-1:0]   w_prod_step;

    assign w_is_mul       = (in_func == FN_MUL);
    assign w_busy         = (state_q == S_BUSY);
    assign w_prod_step    = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    assign w_mul_done     = w_busy && (cnt_q == CNT_LAST);
    assign w_mul_result   = w_prod_step;
    assign w_mul_bt       = mbt_q;
    assign w_mul_tag      = mtag_q;
    assign w_mul_setflags = msf_q;

    // Radix-2 shift-add: one multiplier bit consumed per BUSY cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        mbt_d    = mbt_q;
        mtag_d   = mtag_q;
        msf_d    = msf_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (state_q == S_IDLE) begin
            if (w_accept && w_is_mul) begin
                state_d  = S_BUSY;
                cnt_d    = '0;
                mcand_d  = in_opA;
                mplier_d = w_b;
                prod_d   = '0;
                mbt_d    = w_bt;
                mtag_d   = in_tag;
                msf_d    = in_setflags;
            end
        end else begin
            prod_d   = w_prod_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (w_mul_done) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            mbt_q    <= '0;
            mtag_q   <= '0;
            msf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            mbt_q    <= mbt_d;
            mtag_q   <= mtag_d;
            msf_q    <= msf_d;
        end
    end
`else
    assign w_is_mul       = 1'b0;
    assign w_busy         = 1'b0;
    assign w_mul_done     = 1'b0;
    assign w_mul_result   = '0;
    assign w_mul_bt       = '0;
    assign w_mul_tag      = '0;
    assign w_mul_setflags = 1'b0;
`endif

    // Output slot: flush wins, then a new result, then a downstream pop.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_bt_d     = out_bt_q;
        out_tag_d    = out_tag_q;
        flags_d      = flags_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_load_alu) begin
            out_valid_d  = 1'b1;
            out_result_d = w_alu_result;
            out_bt_d     = w_bt;
            out_tag_d    = in_tag;
            if (in_setflags && w_alu_valid) begin
                flags_d = w_alu_flags;
            end
        end else if (w_load_mul) begin
            out_valid_d  = 1'b1;
            out_result_d = w_mul_result;
            out_bt_d     = w_mul_bt;
            out_tag_d    = w_mul_tag;
            if (w_mul_setflags) begin
                flags_d = w_mul_flags;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_bt_q     <= '0;
            out_tag_q    <= '0;
            flags_q      <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_bt_q     <= out_bt_d;
            out_tag_q    <= out_tag_d;
            flags_q      <= flags_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_result        = out_result_q;
    assign out_zero          = (out_result_q == '0);
    assign out_branch_target = out_bt_q;
    assign out_tag           = out_tag_q;
    assign out_flags         = flags_q;

endmodule

`default_nettype wire
